// File: rtl/tick_debouncer.sv
// Tick-qualified push-button debouncer: 2-flop synchronizer, 4-state qualifier FSM,
// registered edge pulses and a one-shot long-press flag counted in timer ticks.
module tick_debouncer #(
    parameter int STABLE_TICKS = 4,
    parameter int LONG_TICKS   = 100
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic noisy_in,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic long_press,
    output logic busy
);

    localparam int SYNC_STAGES = 2;
    localparam int STAB_W      = $clog2(STABLE_TICKS + 1);
    localparam int HOLD_W      = $clog2(LONG_TICKS + 1);

    localparam logic [STAB_W-1:0] STAB_LAST = STAB_W'(STABLE_TICKS - 1);
    localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);

    typedef enum logic [1:0] {
        LOW     = 2'b00,
        WAIT_HI = 2'b01,
        HIGH    = 2'b11,
        WAIT_LO = 2'b10
    } state_t;

    // ------------------------------------------------------------------
    // Input synchronizer
    // ------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_reg;
    logic [SYNC_STAGES-1:0] sync_next;
    logic                   sync_in;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            if (gi == 0) begin : g_first
                assign sync_next[gi] = noisy_in;
            end else begin : g_chain
                assign sync_next[gi] = sync_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= sync_next;
        end
    end

    assign sync_in = sync_reg[SYNC_STAGES-1];

    // ------------------------------------------------------------------
    // State register and counters
    // ------------------------------------------------------------------
    state_t            state_reg;
    state_t            state_next;
    logic [STAB_W-1:0] stab_reg;
    logic [STAB_W-1:0] stab_next;
    logic [HOLD_W-1:0] hold_reg;
    logic [HOLD_W-1:0] hold_next;

    logic clean_reg, clean_next;
    logic rise_reg,  rise_next;
    logic fall_reg,  fall_next;
    logic long_reg,  long_next;
    logic busy_reg,  busy_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg <= LOW;
            stab_reg  <= '0;
            hold_reg  <= '0;
            clean_reg <= 1'b0;
            rise_reg  <= 1'b0;
            fall_reg  <= 1'b0;
            long_reg  <= 1'b0;
            busy_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stab_reg  <= stab_next;
            hold_reg  <= hold_next;
            clean_reg <= clean_next;
            rise_reg  <= rise_next;
            fall_reg  <= fall_next;
            long_reg  <= long_next;
            busy_reg  <= busy_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        stab_next  = stab_reg;
        case (state_reg)
            LOW: begin
                stab_next = '0;
                if (sync_in) begin
                    state_next = WAIT_HI;
                end
            end
            HIGH: begin
                stab_next = '0;
                if (!sync_in) begin
                    state_next = WAIT_LO;
                end
            end
            WAIT_HI: begin
                // A bounce back to the old level beats a coincident tick.
                if (!sync_in) begin
                    state_next = LOW;
                    stab_next  = '0;
                end else if (tick) begin
                    if (stab_reg == STAB_LAST) begin
                        state_next = HIGH;
                        stab_next  = '0;
                    end else begin
                        stab_next = stab_reg + 1'b1;
                    end
                end
            end
            WAIT_LO: begin
                if (sync_in) begin
                    state_next = HIGH;
                    stab_next  = '0;
                end else if (tick) begin
                    if (stab_reg == STAB_LAST) begin
                        state_next = LOW;
                        stab_next  = '0;
                    end else begin
                        stab_next = stab_reg + 1'b1;
                    end
                end
            end
            default: begin
                state_next = LOW;
                stab_next  = '0;
            end
        endcase
    end

    // Hold time restarts only on a genuine new press, so release bounces keep it.
    always_comb begin
        hold_next = hold_reg;
        if (state_reg == WAIT_HI && state_next == HIGH) begin
            hold_next = '0;
        end else if ((state_reg == HIGH || state_reg == WAIT_LO) && tick && hold_reg != HOLD_MAX) begin
            hold_next = hold_reg + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Output logic (registered one edge later alongside the state)
    // ------------------------------------------------------------------
    always_comb begin
        clean_next = (state_next == HIGH) || (state_next == WAIT_LO);
        busy_next  = (state_next == WAIT_HI) || (state_next == WAIT_LO);
        rise_next  = (state_reg == WAIT_HI) && (state_next == HIGH);
        fall_next  = (state_reg == WAIT_LO) && (state_next == LOW);
        long_next  = (hold_next == HOLD_MAX) && (hold_reg != HOLD_MAX);
    end

    assign clean      = clean_reg;
    assign rise       = rise_reg;
    assign fall       = fall_reg;
    assign long_press = long_reg;
    assign busy       = busy_reg;

endmodule

// File: tb/tb_tick_debouncer.sv
// Self-checking bench for tick_debouncer: directed press/release scenarios followed
// by random traffic, all compared cycle by cycle against a tick-counting reference.
module tb_tick_debouncer;

    localparam int ST = 4;
    localparam int LT = 10;

    logic clk = 1'b0;
    logic reset;
    logic tick;
    logic noisy_in;
    logic clean;
    logic rise;
    logic fall;
    logic long_press;
    logic busy;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_rise = 0;
    int n_fall = 0;
    int n_long = 0;

    // Reference: delayed copy of the pin, current accepted level, run of opposing ticks.
    bit m_s1, m_s2;
    bit m_clean, m_pend;
    int m_run, m_hold;
    bit e_clean, e_rise, e_fall, e_long, e_busy;

    tick_debouncer #(
        .STABLE_TICKS(ST),
        .LONG_TICKS  (LT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .tick      (tick),
        .noisy_in  (noisy_in),
        .clean     (clean),
        .rise      (rise),
        .fall      (fall),
        .long_press(long_press),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic got, input logic exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0b exp=%0b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        checks++;
        assert (got == exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic model_edge(input logic t, input logic n, input logic r);
        bit sync, was_clean, flipped;
        e_rise = 1'b0;
        e_fall = 1'b0;
        e_long = 1'b0;
        if (r) begin
            m_s1 = 0; m_s2 = 0; m_clean = 0; m_pend = 0; m_run = 0; m_hold = 0;
        end else begin
            sync      = m_s2;
            was_clean = m_clean;
            flipped   = 0;
            if (!m_pend) begin
                if (sync != m_clean) begin
                    m_pend = 1;
                    m_run  = 0;
                end
            end else if (sync == m_clean) begin
                m_pend = 0;
                m_run  = 0;
            end else if (t) begin
                m_run++;
                if (m_run == ST) begin
                    m_clean = !m_clean;
                    m_pend  = 0;
                    m_run   = 0;
                    flipped = 1;
                end
            end
            if (flipped && m_clean) begin
                m_hold = 0;
                e_rise = 1'b1;
            end else begin
                if (flipped) e_fall = 1'b1;
                if (was_clean && t && m_hold < LT) begin
                    m_hold++;
                    if (m_hold == LT) e_long = 1'b1;
                end
            end
            m_s2 = m_s1;
            m_s1 = n;
        end
        e_clean = m_clean;
        e_busy  = m_pend;
    endtask

    task automatic step(input logic t, input logic n, input logic r);
        tick     = t;
        noisy_in = n;
        reset    = r;
        @(posedge clk);
        model_edge(t, n, r);
        cyc++;
        #1;
        if (rise === 1'b1) n_rise++;
        if (fall === 1'b1) n_fall++;
        if (long_press === 1'b1) n_long++;
        chk("clean", clean, e_clean);
        chk("rise", rise, e_rise);
        chk("fall", fall, e_fall);
        chk("long_press", long_press, e_long);
        chk("busy", busy, e_busy);
        chk("rise_fall_excl", rise & fall, 1'b0);
    endtask

    function automatic logic tick_at(input int c);
        return (c % 10) == 9;
    endfunction

    task automatic run(input int n, input logic level);
        for (int i = 0; i < n; i++) step(tick_at(cyc), level, 1'b0);
    endtask

    task automatic align(input logic level);
        while (cyc % 10 != 0) step(tick_at(cyc), level, 1'b0);
    endtask

    task automatic report(input string name);
        $display("phase %-10s cyc=%0d rise=%0d fall=%0d long=%0d clean=%0b", name, cyc, n_rise, n_fall, n_long, clean);
    endtask

    initial begin
        int r0, f0, l0;
        logic lvl;
        logic held;

        // Reset with a live input: synchronizer must still come out cleared.
        for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 1'b1);
        report("reset");
        run(20, 1'b0);

        // Press: busy three clocks after the pin rises, single rise pulse.
        align(1'b0);
        for (int k = 0; k < 3; k++) begin
            step(tick_at(cyc), 1'b1, 1'b0);
            chk("busy_3clk", busy, 1'(k == 2));
        end
        r0 = n_rise; l0 = n_long;
        run(50, 1'b1);
        chk_int("press_rise_count", n_rise - r0, 1);
        chk("press_clean", clean, 1'b1);
        report("press");

        // Keep holding for about 30 ticks: exactly one long-press pulse.
        run(300, 1'b1);
        chk_int("long_press_count", n_long - l0, 1);
        report("hold");

        // Bouncy release, then steady low.
        f0 = n_fall;
        for (int i = 0; i < 50; i++) step(tick_at(cyc), 1'((i / 3) % 2), 1'b0);
        chk("bounce_clean_high", clean, 1'b1);
        chk_int("bounce_no_fall", n_fall - f0, 0);
        run(80, 1'b0);
        chk_int("release_fall_count", n_fall - f0, 1);
        report("release");

        // Three ticks, 2-clk glitch low, then only four fresh ticks qualify.
        align(1'b0);
        r0 = n_rise;
        run(30, 1'b1);
        run(2, 1'b0);
        run(36, 1'b1);
        chk_int("glitch_no_rise_yet", n_rise - r0, 0);
        chk("glitch_clean_low", clean, 1'b0);
        run(20, 1'b1);
        chk_int("glitch_rise_after", n_rise - r0, 1);
        run(80, 1'b0);
        report("glitch");

        // Synchronized input returns to the clean level exactly on a tick.
        align(1'b0);
        run(17, 1'b0 | 1'b1);
        run(2, 1'b0);
        chk("tick_abort_busy", busy, 1'b1);
        step(tick_at(cyc), 1'b0, 1'b0);
        chk("tick_abort_idle", busy, 1'b0);
        run(30, 1'b0);
        report("tick_abort");

        // Reset during WAIT_HI with three ticks already counted.
        align(1'b0);
        r0 = n_rise; f0 = n_fall;
        run(32, 1'b1);
        chk("pre_reset_busy", busy, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        chk("reset_clean", clean, 1'b0);
        chk("reset_busy", busy, 1'b0);
        run(36, 1'b1);
        chk_int("requal_no_rise", n_rise - r0, 0);
        run(20, 1'b1);
        chk_int("requal_rise", n_rise - r0, 1);
        chk_int("reset_no_fall", n_fall - f0, 0);
        run(80, 1'b0);
        report("mid_reset");

        // No ticks at all: noise must not move clean.
        held = clean;
        for (int i = 0; i < 200; i++) step(1'b0, 1'($urandom_range(0, 1)), 1'b0);
        chk("no_tick_clean_held", clean, held);
        report("no_tick");

        // Random traffic against the reference.
        lvl = 1'b0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 5) == 0) lvl = ~lvl;
            step(1'($urandom_range(0, 3) == 0), lvl, 1'($urandom_range(0, 399) == 0));
        end
        report("random");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tick_debouncer.md
TICK_DEBOUNCER -- requirements
Module: tick_debouncer

Interface
REQ-001 Parameter STABLE_TICKS, default 4, SHALL set the number of consecutive qualifying ticks needed to accept a new input level; legal range 1..255.
REQ-002 Parameter LONG_TICKS, default 100, SHALL set the ticks in the high state before a long-press is flagged; legal when LONG_TICKS > STABLE_TICKS.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 tick  input  1  SHALL be a one-clk-wide sample strobe from the periodic timer; any cycle with tick=1 is one tick.
REQ-006 noisy_in  input  1  SHALL be the raw asynchronous button/contact level.
REQ-007 clean  output  1  SHALL be the debounced level.
REQ-008 rise  output  1  SHALL be a one-cycle pulse when clean goes 0->1.
REQ-009 fall  output  1  SHALL be a one-cycle pulse when clean goes 1->0.
REQ-010 long_press  output  1  SHALL be a one-cycle pulse when clean has been high for LONG_TICKS ticks.
REQ-011 busy  output  1  SHALL be 1 while a level change is being qualified (WAIT_HI or WAIT_LO).

Function
REQ-012 noisy_in SHALL pass through a 2-flop synchronizer; the second-flop output (sync_in) is the only value the FSM sees.
REQ-013 FSM states SHALL be LOW, WAIT_HI, HIGH, WAIT_LO; clean=1 exactly in HIGH and WAIT_LO.
REQ-014 LOW -> WAIT_HI when sync_in=1; stab_cnt cleared on entry.
REQ-015 HIGH -> WAIT_LO when sync_in=0; stab_cnt cleared on entry.
REQ-016 In WAIT_x, a cycle with sync_in equal to the current clean level SHALL return to the originating stable state and clear stab_cnt (abort).
REQ-017 In WAIT_x, a cycle with tick=1 and sync_in differing from clean SHALL increment stab_cnt; cycles with tick=0 SHALL hold stab_cnt.
REQ-018 On the qualifying tick where stab_cnt==STABLE_TICKS-1, the FSM SHALL move to the new stable state; clean, rise/fall update on the following clk edge (registered outputs).
REQ-019 Abort SHALL have priority over a simultaneous tick: sync_in back to clean level in the same cycle as tick=1 aborts, no increment.
REQ-020 stab_cnt width SHALL be $clog2(STABLE_TICKS+1) bits; it never exceeds STABLE_TICKS-1.
REQ-021 hold_cnt SHALL clear on entry to HIGH, increment on each tick in HIGH or WAIT_LO, and saturate at LONG_TICKS; width $clog2(LONG_TICKS+1).
REQ-022 long_press SHALL pulse once in the cycle after hold_cnt reaches LONG_TICKS; never again until clean returns to 0 and a new press is accepted.
REQ-023 An aborted WAIT_LO (bounce during release) SHALL NOT clear hold_cnt.
REQ-024 rise and fall SHALL never be 1 in the same cycle; rise, fall and long_press each last exactly one clk.
REQ-025 Without ticks, clean SHALL never change regardless of noisy_in.

Reset
REQ-026 While reset=1: state=LOW, clean=0, rise=0, fall=0, long_press=0, busy=0, stab_cnt=0, hold_cnt=0, synchronizer flops=0.
REQ-027 Reset mid-qualification or in HIGH SHALL discard all progress with no fall pulse; after release, a high sync_in restarts qualification from stab_cnt=0.

Verification (STABLE_TICKS=4, LONG_TICKS=10, tick every 10 clk)
REQ-028 noisy_in 0->1 held -> busy=1 three clk later; clean=1 and rise=1 one clk after the 4th tick; rise exactly 1 clk wide.
REQ-029 noisy_in high for 3 ticks then glitches low 2 clk, then high -> abort, counter restarts; clean rises only after 4 further uninterrupted ticks.
REQ-030 Press held 10 ticks after clean=1 -> single long_press pulse; held 30 ticks total -> still exactly one pulse.
REQ-031 Release with bounce (0/1 alternating every 3 clk for 50 clk) then steady 0 -> clean stays 1 during bounce, fall=1 once after 4 stable ticks.
REQ-032 Input toggles as sync_in returns to clean on the same cycle as tick=1 -> no increment, state returns to stable.
REQ-033 reset asserted 1 clk while in WAIT_HI with stab_cnt=3 -> all outputs 0, no rise/fall, requalification takes 4 full ticks.
